// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword bit positions, field widths and
// the syndrome equations used by both the encoder and the decoder.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int PAR_W  = 3;

  // Bit index = (1-based Hamming position) - 1
  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D0_IDX = 2;
  localparam int P3_IDX = 3;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;

  // Each syndrome bit covers the positions whose 1-based index has that bit
  // set, so a single flipped bit yields its own position as the syndrome.
  function automatic logic [PAR_W-1:0] calc_syndrome(input logic [CODE_W-1:0] code);
    logic [PAR_W-1:0] s;
    s[0] = code[P1_IDX] ^ code[D0_IDX] ^ code[D1_IDX] ^ code[D3_IDX];
    s[1] = code[P2_IDX] ^ code[D0_IDX] ^ code[D2_IDX] ^ code[D3_IDX];
    s[2] = code[P3_IDX] ^ code[D1_IDX] ^ code[D2_IDX] ^ code[D3_IDX];
    return s;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generator for one Hamming(7,4) codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [PAR_W-1:0]  syndrome_o
);

  assign syndrome_o = calc_syndrome(code_i);

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage Hamming(7,4) single-error-correcting decoder with valid/ready
// flow control and a saturating count of corrected beats.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_parity,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_err,
  output logic              out_err_data,
  output logic [CNT_W-1:0]  corr_count,
  input  logic              clr_count
);

  logic              advance;
  logic [PAR_W-1:0]  syndrome;

  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic [PAR_W-1:0]  s1_syn_q;

  logic              s2_valid_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PAR_W-1:0]  parity_q, parity_d;
  logic [PAR_W-1:0]  syn_q;
  logic              err_q, err_d;
  logic              errd_q, errd_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] flip_mask;
  logic [CODE_W-1:0] corr_code;

  // Whole pipeline moves together; a full output slot stalls both stages.
  assign advance  = ~s2_valid_q | out_ready;
  assign in_ready = advance;

  hamming_syndrome u_syndrome (
    .code_i     (in_code),
    .syndrome_o (syndrome)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= in_code;
        s1_syn_q  <= syndrome;
      end
    end
  end

  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < CODE_W; i++) begin
      flip_mask[i] = (s1_syn_q == PAR_W'(i + 1));
    end
    corr_code = s1_code_q ^ flip_mask;
    data_d    = {corr_code[D3_IDX], corr_code[D2_IDX], corr_code[D1_IDX], corr_code[D0_IDX]};
    parity_d  = {corr_code[P3_IDX], corr_code[P2_IDX], corr_code[P1_IDX]};
    err_d     = |s1_syn_q;
    errd_d    = flip_mask[D0_IDX] | flip_mask[D1_IDX] | flip_mask[D2_IDX] | flip_mask[D3_IDX];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      parity_q   <= '0;
      syn_q      <= '0;
      err_q      <= 1'b0;
      errd_q     <= 1'b0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q   <= data_d;
        parity_q <= parity_d;
        syn_q    <= s1_syn_q;
        err_q    <= err_d;
        errd_q   <= errd_d;
      end
    end
  end

  // Clear has priority over a coinciding corrected-beat increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && err_q && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = data_q;
  assign out_parity   = parity_q;
  assign out_syndrome = syn_q;
  assign out_err      = err_q;
  assign out_err_data = errd_q;
  assign corr_count   = cnt_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard testbench for hamming_decoder: directed codewords with
// hand-derived expectations, checked by an independent output monitor.
module tb_hamming_decoder;
  import hamming_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_code = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;
  logic [2:0] out_parity;
  logic [2:0] out_syndrome;
  logic       out_err;
  logic       out_err_data;
  logic [1:0] corr_count;
  logic       clr_count = 1'b0;

  typedef struct {
    logic [3:0] data;
    logic [2:0] par;
    logic [2:0] syn;
    logic       err;
    logic       errd;
  } exp_t;

  exp_t       expQ[$];
  exp_t       monE;
  logic       monInc;
  logic [1:0] cntModel = '0;
  int         testsRun = 0;
  int         testsFailed = 0;

  always #5 clk = ~clk;

  hamming_decoder #(.CNT_W(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_parity   (out_parity),
    .out_syndrome (out_syndrome),
    .out_err      (out_err),
    .out_err_data (out_err_data),
    .corr_count   (corr_count),
    .clr_count    (clr_count)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mkExp(input logic [3:0] d, input logic [2:0] p, input logic [2:0] s,
                                 input logic e, input logic ed);
    exp_t r;
    r.data = d; r.par = p; r.syn = s; r.err = e; r.errd = ed;
    return r;
  endfunction

  // Expected response for data d with the bit at 1-based position e flipped
  function automatic exp_t expFor(input logic [3:0] d, input int e);
    exp_t r;
    r.data = d;
    r.par  = {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    r.syn  = 3'(e);
    r.err  = (e != 0);
    r.errd = (e == 3) || (e == 5) || (e == 6) || (e == 7);
    return r;
  endfunction

  function automatic logic [6:0] codeFor(input logic [3:0] d, input int e);
    logic [6:0] c;
    c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    if (e != 0) c[e-1] = ~c[e-1];
    return c;
  endfunction

  task automatic syncEdge();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; the expectation is queued
  // on the accepting edge.
  task automatic applyStimulus(input logic [6:0] code, input exp_t e);
    logic acc;
    in_valid = 1'b1;
    in_code  = code;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      syncEdge();
      if (acc) begin
        expQ.push_back(e);
        return;
      end
    end
    checkOutput("accept timeout", 16'(0), 16'(1));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) syncEdge();
    checkOutput("drain leftover", 16'(expQ.size()), 16'(0));
  endtask

  // Monitor: compares every transferred beat and tracks the counter model.
  always @(negedge clk) begin
    if (reset_n) begin
      monInc = 1'b0;
      checkOutput("corr_count", 16'(corr_count), 16'(cntModel));
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected beat", 16'(1), 16'(0));
        end else begin
          monE = expQ.pop_front();
          checkOutput("out_data", 16'(out_data), 16'(monE.data));
          checkOutput("out_parity", 16'(out_parity), 16'(monE.par));
          checkOutput("out_syndrome", 16'(out_syndrome), 16'(monE.syn));
          checkOutput("out_err", 16'(out_err), 16'(monE.err));
          checkOutput("out_err_data", 16'(out_err_data), 16'(monE.errd));
          monInc = monE.err;
        end
      end
      if (clr_count) cntModel = '0;
      else if (monInc && cntModel != 2'b11) cntModel = cntModel + 2'd1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with a valid beat presented
    in_valid = 1'b1;
    in_code  = 7'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst out_valid", 16'(out_valid), 16'(0));
    checkOutput("rst out_data", 16'(out_data), 16'(0));
    checkOutput("rst out_parity", 16'(out_parity), 16'(0));
    checkOutput("rst out_syndrome", 16'(out_syndrome), 16'(0));
    checkOutput("rst out_err", 16'(out_err), 16'(0));
    checkOutput("rst out_err_data", 16'(out_err_data), 16'(0));
    checkOutput("rst corr_count", 16'(corr_count), 16'(0));
    checkOutput("rst in_ready", 16'(in_ready), 16'(1));
    syncEdge();
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);
    checkOutput("post-rst in_ready", 16'(in_ready), 16'(1));
    checkOutput("post-rst out_valid", 16'(out_valid), 16'(0));
    syncEdge();

    // Two-cycle latency of the first beat
    applyStimulus(7'h55, mkExp(4'b1011, 3'b001, 3'b000, 1'b0, 1'b0));
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency 1 cycle", 16'(out_valid), 16'(0));
    syncEdge();
    @(negedge clk);
    checkOutput("latency 2 cycles", 16'(out_valid), 16'(1));
    syncEdge();

    // Clean stream, then data and parity single errors
    applyStimulus(7'h00, mkExp(4'b0000, 3'b000, 3'b000, 1'b0, 1'b0));
    applyStimulus(7'h55, mkExp(4'b1011, 3'b001, 3'b000, 1'b0, 1'b0));
    applyStimulus(7'h7F, mkExp(4'b1111, 3'b111, 3'b000, 1'b0, 1'b0));
    applyStimulus(7'h45, mkExp(4'b1011, 3'b001, 3'b101, 1'b1, 1'b1));
    drain();
    checkOutput("count after data err", 16'(corr_count), 16'(1));
    applyStimulus(7'h54, mkExp(4'b1011, 3'b001, 3'b001, 1'b1, 1'b0));
    drain();
    checkOutput("count after parity err", 16'(corr_count), 16'(2));

    // Backpressure for 5 cycles mid-stream with a beat waiting at the input
    applyStimulus(codeFor(4'd3, 0), expFor(4'd3, 0));
    applyStimulus(codeFor(4'd6, 0), expFor(4'd6, 0));
    applyStimulus(codeFor(4'd9, 0), expFor(4'd9, 0));
    out_ready = 1'b0;
    in_code   = codeFor(4'd12, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall in_ready", 16'(in_ready), 16'(0));
      checkOutput("stall out_valid", 16'(out_valid), 16'(1));
      checkOutput("stall out_data", 16'(out_data), 16'(4'd6));
      checkOutput("stall out_parity", 16'(out_parity), 16'(expFor(4'd6, 0).par));
      syncEdge();
    end
    out_ready = 1'b1;
    applyStimulus(codeFor(4'd12, 0), expFor(4'd12, 0));
    drain();

    // Every data value with every single-bit error position
    for (int d = 0; d < 16; d++) begin
      for (int e = 0; e < 8; e++) begin
        applyStimulus(codeFor(4'(d), e), expFor(4'(d), e));
      end
    end
    drain();
    checkOutput("count saturated", 16'(corr_count), 16'(3));

    // Park an error beat, then release it in the same cycle as a clear
    applyStimulus(codeFor(4'd5, 3), expFor(4'd5, 3));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    syncEdge();
    syncEdge();
    out_ready = 1'b1;
    clr_count = 1'b1;
    syncEdge();
    clr_count = 1'b0;
    @(negedge clk);
    checkOutput("clear wins", 16'(corr_count), 16'(0));
    checkOutput("clear drained", 16'(expQ.size()), 16'(0));
    syncEdge();

    // Reset mid-stream discards in-flight beats
    applyStimulus(codeFor(4'd1, 0), expFor(4'd1, 0));
    applyStimulus(codeFor(4'd2, 7), expFor(4'd2, 7));
    in_valid = 1'b0;
    reset_n  = 1'b0;
    expQ.delete();
    cntModel = '0;
    syncEdge();
    @(negedge clk);
    checkOutput("mid-rst out_valid", 16'(out_valid), 16'(0));
    syncEdge();
    reset_n = 1'b1;
    applyStimulus(codeFor(4'd10, 6), expFor(4'd10, 6));
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("re-latency 1 cycle", 16'(out_valid), 16'(0));
    syncEdge();
    @(negedge clk);
    checkOutput("re-latency 2 cycles", 16'(out_valid), 16'(1));
    syncEdge();
    drain();
    checkOutput("count after reset", 16'(corr_count), 16'(1));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
